// File: rtl/i2s_tx_ctrl.sv
// I2S (Philips) master transmitter: drains stereo words from the TX FIFO and drives SCK/WS/SD.
// Build option I2S_TX_UNDERRUN_REPEAT_EN: an underrun frame repeats the last popped word instead of silence.
module i2s_tx_ctrl #(
  parameter int SAMPLE_W  = 16,
  parameter int CLK_DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CLK_DIV_W-1:0]  clk_div,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_ack,
  input  logic                  underrun_clr,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic                  underrun,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               state;
  logic [CLK_DIV_W-1:0] div_q;
  logic [CLK_DIV_W-1:0] div_cnt;
  logic                 sck;
  logic [BIT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic [FRAME_W-1:0]   fill_word;
  logic                 tick;
  logic                 fall_tick;
  logic                 frame_end;
  logic                 underrun_set;

  assign tick         = (state == ST_RUN) && (div_cnt == div_q);
  assign fall_tick    = tick && sck;
  assign frame_end    = fall_tick && (bit_cnt == BIT_W'(FRAME_W - 1));
  assign underrun_set = frame_end && enable && !fifo_valid;

  // Handshake: fifo_data is taken in any cycle where fifo_valid && fifo_ack; the FIFO
  // pops on that same clock edge. fifo_ack only rises at frame start, so at most one per frame.
  assign fifo_ack = fifo_valid && enable &&
                    ((state == ST_START) || frame_end);

  assign i2s_sck   = sck;
  assign i2s_sd    = (state == ST_RUN) && shreg[FRAME_W-1];
  // WS switches one bit ahead of the channel's MSB.
  assign i2s_ws    = (state == ST_RUN) &&
                     (bit_cnt >= BIT_W'(SAMPLE_W - 1)) &&
                     (bit_cnt <= BIT_W'(FRAME_W - 2));
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0] last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word <= '0;
    end else if (fifo_ack) begin
      last_word <= fifo_data;
    end
  end

  assign fill_word = last_word;
`else
  assign fill_word = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      div_cnt <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sck     <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          shreg   <= '0;
          if (enable) begin
            div_q <= clk_div;
            state <= ST_START;
          end
        end
        ST_START: begin
          sck     <= 1'b0;
          div_cnt <= '0;
          if (!enable) begin
            state <= ST_IDLE;
          end else if (fifo_valid) begin
            shreg   <= fifo_data;
            bit_cnt <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (fall_tick) begin
            if (frame_end) begin
              bit_cnt <= '0;
              if (!enable) begin
                shreg <= '0;
                state <= ST_IDLE;
              end else if (fifo_valid) begin
                shreg <= fifo_data;
              end else begin
                shreg <= fill_word;
              end
            end else begin
              shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new underrun outranks a simultaneous clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: FIFO model, SD/WS capture on SCK rising edges, frame/ack timing checks.
module tb_i2s_tx_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  clk_div;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ack;
  logic        underrun_clr;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] rx_ws_q[$];
  int          ack_cyc[$];
  int          cyc = 0;
  int          ack_cnt = 0;
  int          clr_at = -1;
  int          rx_cnt = 0;
  int          rise_last = 0;
  int          rise_period = 0;
  logic        prev_sck = 1'b0;
  logic [31:0] rx_word = '0;
  logic [31:0] rx_ws = '0;
  logic [31:0] under_word;

  i2s_tx_ctrl #(.SAMPLE_W(16), .CLK_DIV_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clk_div      (clk_div),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_ack     (fifo_ack),
    .underrun_clr (underrun_clr),
    .i2s_sck      (i2s_sck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .underrun     (underrun),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_fifo();
    fifo_valid = (fifo_q.size() > 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic clear_capture();
    rx_q.delete();
    rx_ws_q.delete();
    ack_cyc.delete();
    ack_cnt  = 0;
    rx_cnt   = 0;
    prev_sck = 1'b0;
  endtask

  // one clk cycle: sample at negedge, update FIFO model and inputs #1 after posedge
  task automatic step();
    logic ack_seen;
    @(negedge clk);
    ack_seen = fifo_ack;
    if (fifo_ack) begin
      ack_cnt++;
      ack_cyc.push_back(cyc);
    end
    if (!busy) begin
      rx_cnt = 0;
    end else if (i2s_sck && !prev_sck) begin
      rx_word     = {rx_word[30:0], i2s_sd};
      rx_ws       = {rx_ws[30:0], i2s_ws};
      rise_period = cyc - rise_last;
      rise_last   = cyc;
      rx_cnt++;
      if (rx_cnt == 32) begin
        rx_q.push_back(rx_word);
        rx_ws_q.push_back(rx_ws);
        rx_cnt = 0;
      end
    end
    prev_sck = i2s_sck;
    @(posedge clk);
    #1;
    cyc++;
    if (ack_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    apply_fifo();
    underrun_clr = (cyc == clr_at);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_frames(input string tag, input int want, input int budget);
    int n = 0;
    while (rx_q.size() < want && n < budget) begin
      step();
      n++;
    end
    check(tag, rx_q.size(), want);
  endtask

  task automatic wait_acks(input string tag, input int want, input int budget);
    int n = 0;
    while (ack_cnt < want && n < budget) begin
      step();
      n++;
    end
    check(tag, ack_cnt, want);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic pulse_clr();
    clr_at = cyc + 1;
    run(3);
  endtask

  task automatic check_frames(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("%s_sd%0d", tag, i), rx_q[i], exp_q[i]);
        check($sformatf("%s_ws%0d", tag, i), rx_ws_q[i], 32'h0001_FFFE);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    clk_div      = 8'd1;
    underrun_clr = 1'b0;
    fifo_valid   = 1'b0;
    fifo_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_sck", i2s_sck, 1'b0);
    check("rst_ws", i2s_ws, 1'b0);
    check("rst_sd", i2s_sd, 1'b0);
    check("rst_ack", fifo_ack, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;

    // single word, then FIFO empty at the next frame end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    under_word = 32'hA5A5_0F0F;
`else
    under_word = 32'h0;
`endif
    clear_capture();
    fifo_q.push_back(32'hA5A5_0F0F);
    apply_fifo();
    enable = 1'b1;
    wait_frames("t1_frames", 2, 400);
    exp_q = '{32'hA5A5_0F0F, under_word};
    check_frames("t1");
    check("t1_acks", ack_cnt, 1);
    check("t1_underrun", underrun, 1'b1);
    check("t1_sck_period", rise_period, 4);
    enable = 1'b0;
    wait_idle("t1_idle", 300);
    pulse_clr();
    check("t3_clr", underrun, 1'b0);

    // four preloaded words, continuous stream; clear collides with the next underrun
    clear_capture();
    fifo_q = '{32'h1111_2222, 32'h8001_7FFE, 32'hFFFF_0000, 32'h0F0F_F0F0};
    apply_fifo();
    enable = 1'b1;
    wait_acks("t2_acks", 4, 700);
    check("t2_no_underrun", underrun, 1'b0);
    if (ack_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check($sformatf("t2_ack_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 128);
      clr_at = ack_cyc[3] + 128;
    end
    while (cyc < clr_at + 3) step();
    check("t6_set_wins", underrun, 1'b1);
    wait_frames("t2_frames", 5, 300);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    under_word = 32'h0F0F_F0F0;
`endif
    exp_q = '{32'h1111_2222, 32'h8001_7FFE, 32'hFFFF_0000, 32'h0F0F_F0F0, under_word};
    check_frames("t2");
    check("t2_acks_total", ack_cnt, 4);
    enable = 1'b0;
    wait_idle("t2_idle", 300);
    pulse_clr();

    // enable dropped at bit 5: frame finishes, nothing more popped
    clear_capture();
    fifo_q = '{32'h1234_5678, 32'h9ABC_DEF0};
    apply_fifo();
    enable = 1'b1;
    for (int n = 0; n < 300 && !(busy && rx_cnt == 5); n++) step();
    enable = 1'b0;
    wait_idle("t4_idle", 300);
    check("t4_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t4_word", rx_q[0], 32'h1234_5678);
    run(40);
    check("t4_acks", ack_cnt, 1);
    check("t4_fifo_left", fifo_q.size(), 1);
    check("t4_sck", i2s_sck, 1'b0);
    check("t4_ws", i2s_ws, 1'b0);
    check("t4_sd", i2s_sd, 1'b0);
    check("t4_underrun", underrun, 1'b0);

    // reset mid-frame, restart at clk/2
    clear_capture();
    fifo_q = '{32'hFFFF_FFFF};
    apply_fifo();
    enable = 1'b1;
    run(40);
    check("t5_busy_pre", busy, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_sck", i2s_sck, 1'b0);
    check("t5_ws", i2s_ws, 1'b0);
    check("t5_sd", i2s_sd, 1'b0);
    check("t5_ack", fifo_ack, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    enable  = 1'b0;
    clk_div = 8'd0;
    clear_capture();
    fifo_q = '{32'hAAAA_5555, 32'h0001_8000};
    apply_fifo();
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_acks("t5_acks", 2, 200);
    if (ack_cyc.size() == 2) check("t5_ack_gap", ack_cyc[1] - ack_cyc[0], 64);
    wait_frames("t5_frames", 2, 200);
    exp_q = '{32'hAAAA_5555, 32'h0001_8000};
    check_frames("t5");
    check("t5_sck_period", rise_period, 2);
    enable = 1'b0;
    wait_idle("t5_idle", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
